sub_dec8bit_pipe: RTL

SUB_DEC8BIT_PIPE -- requirements
Module: sub_dec8bit_pipe

---
 rtl/sub_dec8bit_pipe.sv | 106 ++++++++++
 1 files changed

// File: rtl/sub_dec8bit_pipe.sv
// 8-bit subtractor D = A - B - Bin, built as A + ~B + ~Bin on a three-stage
// Kogge-Stone prefix pipeline with valid/ready flow control and a flush input.
module sub_dec8bit_pipe (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Bin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] D,
    output logic       Bout,
    output logic       busy
);

    logic       en;
    logic       v1_reg, v2_reg, v3_reg;
    logic [7:0] p1_reg, g1_reg;
    logic       c0_reg;
    logic [8:0] gs2_reg, ps2_reg;
    logic [7:0] p2_reg;
    logic [7:0] d_reg;
    logic       bout_reg;

    // Prefix network over 9 positions: position 0 carries c0 (g = c0, p = 0),
    // position i+1 carries bit i. Level gl has span 1 << gl.
    logic [3:0][8:0] src_g, src_p, dst_g;
    logic [2:0][8:0] dst_p;

    assign src_g[0] = {g1_reg, c0_reg};
    assign src_p[0] = {p1_reg, 1'b0};
    assign src_g[1] = dst_g[0];
    assign src_p[1] = dst_p[0];
    assign src_g[2] = gs2_reg;
    assign src_p[2] = ps2_reg;
    assign src_g[3] = dst_g[2];
    assign src_p[3] = dst_p[2];

    genvar gl, gi;
    generate
        for (gl = 0; gl < 4; gl++) begin : g_level
            for (gi = 0; gi < 9; gi++) begin : g_node
                logic g_lo, p_lo;
                // Positions below the span combine with the identity pair (g=0, p=1).
                if (gi >= (1 << gl)) begin : g_span
                    assign g_lo = src_g[gl][gi - (1 << gl)];
                    assign p_lo = src_p[gl][gi - (1 << gl)];
                end else begin : g_ident
                    assign g_lo = 1'b0;
                    assign p_lo = 1'b1;
                end
                assign dst_g[gl][gi] = src_g[gl][gi] | (src_p[gl][gi] & g_lo);
                if (gl < 3) begin : g_prop
                    assign dst_p[gl][gi] = src_p[gl][gi] & p_lo;
                end
            end
        end
    endgenerate

    assign en        = !v3_reg || out_ready;
    assign in_ready  = en;
    assign out_valid = v3_reg;
    assign D         = d_reg;
    assign Bout      = bout_reg;
    assign busy      = v1_reg | v2_reg | v3_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_reg   <= 1'b0;
            v2_reg   <= 1'b0;
            v3_reg   <= 1'b0;
            p1_reg   <= '0;
            g1_reg   <= '0;
            c0_reg   <= 1'b0;
            gs2_reg  <= '0;
            ps2_reg  <= '0;
            p2_reg   <= '0;
            d_reg    <= '0;
            bout_reg <= 1'b0;
        end else begin
            if (en) begin
                v1_reg   <= in_valid;
                p1_reg   <= ~(A ^ B);
                g1_reg   <= A & ~B;
                c0_reg   <= ~Bin;
                v2_reg   <= v1_reg;
                gs2_reg  <= dst_g[1];
                ps2_reg  <= dst_p[1];
                p2_reg   <= p1_reg;
                v3_reg   <= v2_reg;
                // dst_g[3][i] is the carry into bit i; bit 8 is the carry-out.
                d_reg    <= p2_reg ^ dst_g[3][7:0];
                bout_reg <= ~dst_g[3][8];
            end
            if (flush) begin
                v1_reg <= 1'b0;
                v2_reg <= 1'b0;
                v3_reg <= 1'b0;
            end
        end
    end

endmodule
